// File: rtl/cnn_pkg.sv
// cnn_pkg
// Shared definitions for the CNN post-processing blocks: datapath widths,
// int8 saturation limits, the int8 result type and the requant FSM states.
// No ports (package).
package cnn_pkg;

    localparam int DOT_W  = 36;
    localparam int BIAS_W = 32;
    localparam int Q_MAX  = 127;
    localparam int Q_MIN  = -128;

    typedef logic signed [7:0] int8_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } req_state_t;

endpackage

// File: rtl/requant_sat.sv
// requant_sat
// Combinational requantizer: adds the round-half-up constant for the
// requested shift, arithmetic-shifts right, then saturates to int8.
// Optional macro DOT_REQUANT_RELU_EN: when defined, negative results are
// clamped to 0 after saturation.
// Ports:
//   i_sum    in  IN_W  signed pre-shift sum
//   i_shift  in  5     right-shift amount, 0..31
//   o_q      out 8     signed int8 result
module requant_sat #(
    parameter int IN_W = cnn_pkg::DOT_W + 1
) (
    input  logic signed [IN_W-1:0] i_sum,
    input  logic        [4:0]      i_shift,
    output logic signed [7:0]      o_q
);
    import cnn_pkg::*;

    // One guard bit so adding the rounding constant can never wrap.
    localparam int W = IN_W + 1;
    localparam logic signed [W-1:0] SAT_HI = W'(Q_MAX);
    localparam logic signed [W-1:0] SAT_LO = W'(Q_MIN);

    logic signed [W-1:0] w_ext;
    logic signed [W-1:0] w_half;
    logic signed [W-1:0] w_rounded;
    logic signed [W-1:0] w_shifted;
    int8_t               w_sat;

    // Round half up, then floor-shift; a shift of zero adds nothing.
    always_comb begin
        w_ext  = {i_sum[IN_W-1], i_sum};
        w_half = '0;
        if (i_shift != 5'd0) begin
            w_half = W'(1) << (i_shift - 5'd1);
        end
        w_rounded = w_ext + w_half;
        w_shifted = w_rounded >>> i_shift;
    end

    // Clamp into the int8 range, with the optional ReLU floor applied last.
    always_comb begin
        if (w_shifted > SAT_HI) begin
            w_sat = int8_t'(Q_MAX);
        end else if (w_shifted < SAT_LO) begin
            w_sat = int8_t'(Q_MIN);
        end else begin
            w_sat = w_shifted[7:0];
        end
`ifdef DOT_REQUANT_RELU_EN
        o_q = w_sat[7] ? 8'sd0 : w_sat;
`else
        o_q = w_sat;
`endif
    end

endmodule

// File: rtl/dot_requant.sv
// dot_requant
// Post-processing stage behind the MAC array: counts dot-product beats per
// window, captures the completed sum plus bias (stage 1), requantizes it to
// int8 (stage 2, requant_sat) and queues the result in a 2-entry FIFO with a
// valid/ready handshake.
// Optional macro DOT_REQUANT_RELU_EN (in requant_sat): ReLU clamp on output.
// Ports:
//   clk        in  1       system clock
//   rst        in  1       synchronous active-high reset
//   start      in  1       window start pulse
//   dot_valid  in  1       dot_in beat valid
//   dot_in     in  DOT_W   signed running dot product
//   bias       in  BIAS_W  signed bias, sampled on the completing beat
//   shift      in  5       requant shift, sampled on the completing beat
//   out_ready  in  1       consumer ready
//   out_valid  out 1       FIFO head valid
//   out_data   out 8       signed int8 FIFO head
//   drop       out 1       pulse when a result is lost to a full FIFO
//   busy       out 1       window open, pipeline or FIFO holding data
module dot_requant #(
    parameter int WINDOW_LEN = 4,
    parameter int DOT_W      = cnn_pkg::DOT_W,
    parameter int BIAS_W     = cnn_pkg::BIAS_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     dot_valid,
    input  logic signed [DOT_W-1:0]  dot_in,
    input  logic signed [BIAS_W-1:0] bias,
    input  logic        [4:0]        shift,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic signed [7:0]        out_data,
    output logic                     drop,
    output logic                     busy
);
    import cnn_pkg::*;

    localparam int CNT_W = $clog2(WINDOW_LEN + 1);

    req_state_t              r_state;
    logic [CNT_W-1:0]        r_beatCnt;
    logic                    r_s1Valid;
    logic signed [DOT_W:0]   r_s1Sum;
    logic [4:0]              r_s1Shift;
    int8_t                   r_fifoMem [2];
    logic                    r_wrPtr;
    logic                    r_rdPtr;
    logic [1:0]              r_count;
    logic                    r_drop;

    logic                    w_countBeat;
    logic [CNT_W-1:0]        w_nextCnt;
    logic                    w_complete;
    logic signed [DOT_W:0]   w_sum;
    int8_t                   w_q;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_accept;
    logic                    w_drop;

    // A start pulse opens the window in the same cycle, so a beat arriving
    // alongside it already counts as beat 1.
    always_comb begin
        w_countBeat = dot_valid && (start || (r_state == ACCUM));
        w_nextCnt   = (start ? '0 : r_beatCnt) + CNT_W'(1);
        w_complete  = w_countBeat && (w_nextCnt == CNT_W'(WINDOW_LEN));
        w_sum       = $signed({dot_in[DOT_W-1], dot_in})
                    + $signed({{(DOT_W + 1 - BIAS_W){bias[BIAS_W-1]}}, bias});
    end

    // Window FSM; the beat update is ordered after start so a start+beat
    // cycle lands at count 1 (or completes at once when WINDOW_LEN is 1).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_beatCnt <= '0;
        end else begin
            if (start) begin
                r_state   <= ACCUM;
                r_beatCnt <= '0;
            end
            if (w_countBeat) begin
                if (w_complete) begin
                    r_state   <= IDLE;
                    r_beatCnt <= '0;
                end else begin
                    r_beatCnt <= w_nextCnt;
                end
            end
        end
    end

    // Stage 1: bias-added sum and shift captured on the completing beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s1Sum   <= '0;
            r_s1Shift <= '0;
        end else begin
            r_s1Valid <= w_complete;
            if (w_complete) begin
                r_s1Sum   <= w_sum;
                r_s1Shift <= shift;
            end
        end
    end

    // Stage 2 is purely combinational and feeds the FIFO write port.
    requant_sat #(
        .IN_W (DOT_W + 1)
    ) u_requant_sat (
        .i_sum   (r_s1Sum),
        .i_shift (r_s1Shift),
        .o_q     (w_q)
    );

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    always_comb begin
        w_pop    = (r_count != 2'd0) && out_ready;
        w_full   = (r_count == 2'd2);
        w_accept = r_s1Valid && (!w_full || w_pop);
        w_drop   = r_s1Valid && w_full && !w_pop;
    end

    // Two-entry FIFO with inline pointers and occupancy counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_fifoMem[i] <= '0;
            end
            r_wrPtr <= 1'b0;
            r_rdPtr <= 1'b0;
            r_count <= 2'd0;
            r_drop  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_fifoMem[r_wrPtr] <= w_q;
                r_wrPtr            <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            r_drop <= w_drop;
        end
    end

    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_fifoMem[r_rdPtr];
    assign drop      = r_drop;
    assign busy      = (r_state == ACCUM) || r_s1Valid || (r_count != 2'd0);

endmodule
